// File: rtl/seq110_scan_ctrl.sv
// rtl/seq110_scan_ctrl.sv - two-requester round-robin word scanner counting "110" detections
// Optional build macro: SEQ110_CLEAR_ON_WORD_EN (restart the detector on every accepted word).
module seq110_scan_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    input  logic [WIDTH-1:0]             req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [WIDTH-1:0]             req1_data,
    output logic                         req1_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         done_id,
    output logic [$clog2(WIDTH+1)-1:0]   match_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [1:0] {S0, S1, S2} det_t;

    state_t           state;
    state_t           state_next;
    det_t             det;
    det_t             det_next;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             owner;
    logic             last_id;
    logic             grant1;
    logic             accept;
    logic             bit_in;
    logic             hit;

    // last_id resets to 1 so that requester 0 wins the first contested grant
    always_comb begin
        grant1 = req1_valid;
        if (req0_valid && req1_valid)
            grant1 = ~last_id;
    end

    assign accept = req0_ready | req1_ready;
    assign bit_in = word[idx];
    assign hit    = (det == S2) && !bit_in;

    always_comb begin
        det_next = S0;
        case (det)
            S0:      det_next = bit_in ? S1 : S0;
            S1:      det_next = bit_in ? S2 : S0;
            S2:      det_next = bit_in ? S2 : S0;
            default: det_next = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (idx == '0) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with rst keeps a reset cycle silent even though the state register lags by one edge
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!rst) begin
            req0_ready = (state == IDLE) && req0_valid && !grant1;
            req1_ready = (state == IDLE) && req1_valid && grant1;
            busy       = (state != IDLE);
            done       = (state == REPORT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det       <= S0;
            cnt       <= '0;
            idx       <= '0;
            word      <= '0;
            owner     <= 1'b0;
            last_id   <= 1'b1;
            match_cnt <= '0;
            done_id   <= 1'b0;
        end else begin
            if (accept) begin
                word    <= grant1 ? req1_data : req0_data;
                owner   <= grant1;
                last_id <= grant1;
                cnt     <= '0;
                idx     <= IW'(WIDTH-1);
`ifdef SEQ110_CLEAR_ON_WORD_EN
                det     <= S0;
`else
                det     <= det;
`endif
            end
            if (state == SHIFT) begin
                det <= det_next;
                cnt <= cnt + CW'(hit);
                idx <= idx - 1'b1;
                if (idx == '0) begin
                    match_cnt <= cnt + CW'(hit);
                    done_id   <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq110_scan_ctrl.sv
// tb/tb_seq110_scan_ctrl.sv - vector table, directed corner sequences and random words vs a stream model
module tb_seq110_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid;
    logic [W-1:0]  req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [W-1:0]  req1_data;
    logic          req1_ready;
    logic          busy;
    logic          done;
    logic          done_id;
    logic [CW-1:0] match_cnt;

    seq110_scan_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: arbitration history plus the raw bit stream since the detector last restarted
    int last_gr = -1;
    bit hist[$];
    int held_cnt = 0;
    int held_id  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic model_reset();
        last_gr  = -1;
        hist.delete();
        held_cnt = 0;
        held_id  = 0;
    endtask

    task automatic model_accept(input bit v0, input logic [W-1:0] d0, input bit v1,
                                input logic [W-1:0] d1, output int gid, output int cnt);
        logic [W-1:0] w;
        if (v0 && v1) gid = (last_gr == 0) ? 1 : 0;
        else          gid = v1 ? 1 : 0;
        last_gr = gid;
        w = gid ? d1 : d0;
`ifdef SEQ110_CLEAR_ON_WORD_EN
        hist.delete();
`endif
        cnt = 0;
        for (int i = W-1; i >= 0; i--) begin
            hist.push_back(w[i]);
            if (hist.size() >= 3 && hist[hist.size()-3] && hist[hist.size()-2] && !hist[hist.size()-1])
                cnt++;
            while (hist.size() > 2) void'(hist.pop_front());
        end
    endtask

    // Called just after a rising edge with the DUT idle for the coming cycle
    task automatic do_word(input bit v0, input logic [W-1:0] d0, input bit v1, input logic [W-1:0] d1,
                           input bit use_exp, input int exp_id, input int exp_cnt);
        int gid, mcnt;
        bit bad;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        model_accept(v0, d0, v1, d1, gid, mcnt);
        @(negedge clk);
        check("idle_ready", {req0_ready, req1_ready}, gid ? 2'b01 : 2'b10);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("held_cnt", match_cnt, held_cnt);
        check("held_id", done_id, held_id);
        @(posedge clk); #1;
        bad = 0;
        repeat (W) begin
            @(negedge clk);
            if (!busy || done || req0_ready || req1_ready) bad = 1;
            @(posedge clk); #1;
        end
        check("shift_phase", bad, 0);
        @(negedge clk);
        check("report_done", done, 1);
        check("report_busy", busy, 1);
        check("report_id", done_id, gid);
        check("report_cnt", match_cnt, mcnt);
        if (use_exp) begin
            check("table_id", done_id, exp_id);
            check("table_cnt", match_cnt, exp_cnt);
        end
        held_id  = gid;
        held_cnt = mcnt;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit           rst_b;
        bit           v0;
        logic [W-1:0] d0;
        bit           v1;
        logic [W-1:0] d1;
        int           id;
        int           cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit bad;
        int carry_cnt;
`ifdef SEQ110_CLEAR_ON_WORD_EN
        carry_cnt = 0;
`else
        carry_cnt = 1;
`endif
        tbl[0]  = '{1, 1, 8'b11011000, 0, 8'h00, 0, 2};
        tbl[1]  = '{1, 1, 8'b10110110, 1, 8'hFF, 0, 2};
        tbl[2]  = '{0, 1, 8'h00,       1, 8'hFF, 1, 0};
        tbl[3]  = '{1, 1, 8'h03,       0, 8'h00, 0, 0};
        tbl[4]  = '{0, 1, 8'h00,       0, 8'h00, 0, carry_cnt};
        tbl[5]  = '{0, 1, 8'hFF,       0, 8'h00, 0, 0};
        tbl[6]  = '{1, 1, 8'b10110110, 0, 8'h00, 0, 2};
        tbl[7]  = '{1, 1, 8'hC0,       1, 8'h06, 0, 1};
        tbl[8]  = '{0, 1, 8'hC0,       1, 8'h06, 1, 1};
        tbl[9]  = '{0, 1, 8'hC0,       1, 8'h06, 0, 1};
        tbl[10] = '{0, 1, 8'hC0,       1, 8'h06, 1, 1};
        tbl[11] = '{0, 0, 8'h00,       1, 8'h36, 1, 2};
        tbl[12] = '{0, 0, 8'h00,       1, 8'h00, 1, 0};

        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hAA;
        req1_valid = 1'b1; req1_data = 8'h55;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_id", done_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_b) apply_reset();
            do_word(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, 1'b1, tbl[i].id, tbl[i].cnt);
        end

        // Abort in the 4th SHIFT cycle: no done, silent outputs under reset, next word starts from S0
        apply_reset();
        req0_valid = 1'b1; req0_data = 8'hFF; req1_valid = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", {req0_ready, req1_ready}, 2'b00);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy2", busy, 0);
        check("abort_ready2", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_reset();
        bad = 0;
        repeat (W+2) begin
            @(negedge clk);
            if (done) bad = 1;
            @(posedge clk); #1;
        end
        check("abort_no_done", bad, 0);
        do_word(1'b1, 8'b01100000, 1'b0, 8'h00, 1'b1, 0, 1);

        for (int n = 0; n < 40; n++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            do_word(v0, W'($urandom), v1, W'($urandom), 1'b0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
